// File: rtl/ram_spi_reader.sv
// Frame buffer written by the PPI sequencer and read out by an external SPI master.
// The slave transmitter is SPI mode 0, MSB first, with SPI pins oversampled on clk.
module ram_spi_reader #(
  parameter int DEPTH     = 32,
  parameter int FRAME_LEN = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] adr_wr,
  input  logic [7:0] wr_data,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  output logic       spi_miso,
  output logic       byte_done,
  output logic [7:0] rd_adr,
  output logic       busy,
  output logic       frame_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  // ---------------------------------------------------------------------------
  // Frame RAM
  // ---------------------------------------------------------------------------
  logic [7:0]    ram [DEPTH];
  logic [7:0]    ram_rd;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // NOTE: the RAM has no reset branch; a reset must keep the stored frame, and
  // leaving it out lets synthesis map the array onto real memory.
  always_ff @(posedge clk) begin
    if (we && (32'(adr_wr) < DEPTH)) begin
      ram[AW'(adr_wr)] <= wr_data;
    end
  end

  // Asynchronous read sampled by the FSM at the same edge as a write gives read-first.
  assign ram_rd = ram[AW'(rd_ptr_q)];

  // ---------------------------------------------------------------------------
  // SPI pin synchronisers and edge detectors
  // ---------------------------------------------------------------------------
  logic [1:0] cs_sync, sck_sync;
  logic       cs_hist, sck_hist;
  logic       cs_fall, cs_rise, sck_rise, sck_fall;

  // NOTE: every flop in this design is written with <= so that all of them
  // sample pre-edge values; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync  <= 2'b11;
      cs_hist  <= 1'b1;
      sck_sync <= 2'b00;
      sck_hist <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[0], spi_cs_n};
      cs_hist  <= cs_sync[1];
      sck_sync <= {sck_sync[0], spi_sck};
      sck_hist <= sck_sync[1];
    end
  end

  assign cs_fall  =  cs_hist  & ~cs_sync[1];
  assign cs_rise  = ~cs_hist  &  cs_sync[1];
  assign sck_rise = ~sck_hist &  sck_sync[1];
  assign sck_fall =  sck_hist & ~sck_sync[1];

  // ---------------------------------------------------------------------------
  // Transmit FSM and datapath
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic       miso_q, miso_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       pend_q, pend_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      miso_q    <= 1'b0;
      bit_cnt_q <= '0;
      rd_ptr_q  <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      miso_q    <= miso_d;
      bit_cnt_q <= bit_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every signal driven here gets its default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    miso_d    = miso_q;
    bit_cnt_d = bit_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          rd_ptr_d  = '0;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else begin
          sr_d    = ram_rd;
          miso_d  = ram_rd[7];
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          // bit_cnt 0 (between bytes) and 8 (byte complete) are clean ends.
          state_d = IDLE;
          miso_d  = 1'b0;
          if ((bit_cnt_q != 4'd0) && (bit_cnt_q != 4'd8)) begin
            err_d = 1'b1;
          end
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            done_d   = 1'b1;
            pend_d   = 1'b1;
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (pend_q) begin
            sr_d      = ram_rd;
            miso_d    = ram_rd[7];
            pend_d    = 1'b0;
            bit_cnt_d = '0;
          end else begin
            sr_d   = {sr_q[6:0], 1'b0};
            miso_d = sr_q[6];
          end
        end
      end

      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  assign spi_miso  = miso_q;
  assign byte_done = done_q;
  assign rd_adr    = 8'(rd_ptr_q);
  assign busy      = (state_q != IDLE);
  assign frame_err = err_q;

endmodule

// File: tb/tb_ram_spi_reader.sv
// Bench for ram_spi_reader: acts as sequencer (RAM writes) and SPI master, and compares
// every received byte against a plain array model of the frame buffer.
module tb_ram_spi_reader;

  localparam int DEPTH     = 32;
  localparam int FRAME_LEN = 22;
  localparam int HALF_SCK  = 8;   // clk cycles per SCK half period (SCK = clk/16)

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we = 1'b0;
  logic [7:0] adr_wr = '0;
  logic [7:0] wr_data = '0;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_miso;
  logic       byte_done;
  logic [7:0] rd_adr;
  logic       busy;
  logic       frame_err;

  ram_spi_reader #(
    .DEPTH    (DEPTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .adr_wr   (adr_wr),
    .wr_data  (wr_data),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_miso (spi_miso),
    .byte_done(byte_done),
    .rd_adr   (rd_adr),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [7:0] mem_model [DEPTH];
  logic [7:0] rx_q [$];
  logic       busy_mid;

  // Each clk cycle with byte_done high counts once, so a stretched pulse over-counts.
  always @(negedge clk) if (byte_done === 1'b1) done_cnt++;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sequencer-style write; the model keeps only in-range addresses.
  task automatic ram_write(input int adr, input logic [7:0] data);
    we      = 1'b1;
    adr_wr  = 8'(adr);
    wr_data = data;
    wait_clks(1);
    we      = 1'b0;
    if (adr < DEPTH) mem_model[adr] = data;
  endtask

  // SPI mode-0 master: samples MISO just before each rising SCK edge.
  // hit_bit >= 0 fires a write to hit_adr timed onto the reload after that bit's falling edge.
  task automatic spi_frame(input int nbytes, input int tail_bits, input bit release_cs,
                           input int hit_bit, input int hit_adr, input logic [7:0] hit_data);
    logic [7:0] b;
    b = '0;
    rx_q.delete();
    spi_cs_n = 1'b0;
    wait_clks(HALF_SCK);
    busy_mid = busy;
    for (int n = 0; n < nbytes * 8 + tail_bits; n++) begin
      b = {b[6:0], spi_miso};
      if (n % 8 == 7) rx_q.push_back(b);
      spi_sck = 1'b1;
      wait_clks(HALF_SCK);
      spi_sck = 1'b0;
      if (n == hit_bit) begin
        wait_clks(2);
        we      = 1'b1;
        adr_wr  = 8'(hit_adr);
        wr_data = hit_data;
        wait_clks(1);
        we      = 1'b0;
        wait_clks(HALF_SCK - 3);
      end else begin
        wait_clks(HALF_SCK);
      end
    end
    if (release_cs) begin
      spi_cs_n = 1'b1;
      wait_clks(HALF_SCK);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if ({spi_miso, byte_done, rd_adr, busy, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_during: got miso=%b done=%b rd_adr=%0d busy=%b err=%b, want all 0",
               spi_miso, byte_done, rd_adr, busy, frame_err);
    end
    wait_clks(3);
    reset = 1'b0;
    wait_clks(4);
    checks++;
    if ({spi_miso, byte_done, rd_adr, busy, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_after: got miso=%b done=%b rd_adr=%0d busy=%b err=%b, want all 0",
               spi_miso, byte_done, rd_adr, busy, frame_err);
    end
  endtask

  task automatic test_basic;
    int d0;
    ram_write(0, 8'hA5);
    ram_write(1, 8'h3C);
    d0 = done_cnt;
    spi_frame(2, 0, 1'b1, -1, 0, 8'h00);
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
      errors++;
      $display("FAIL basic_bytes: got %p, want A5 3C", rx_q);
    end
    checks++;
    if (done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses, want 2", done_cnt - d0);
    end
    checks++;
    if (rd_adr !== 8'd2) begin
      errors++;
      $display("FAIL basic_rd_adr: got %0d, want 2", rd_adr);
    end
    checks++;
    if (busy_mid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got mid=%b end=%b, want 1 0", busy_mid, busy);
    end
  endtask

  task automatic test_wrap;
    for (int a = 0; a < FRAME_LEN; a++) ram_write(a, 8'(a));
    spi_frame(FRAME_LEN + 1, 0, 1'b1, -1, 0, 8'h00);
    for (int i = 0; i < FRAME_LEN + 1; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== mem_model[i % FRAME_LEN]) begin
        errors++;
        $display("FAIL wrap_byte%0d: got %h, want %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, mem_model[i % FRAME_LEN]);
      end
    end
    checks++;
    if (rd_adr !== 8'd1) begin
      errors++;
      $display("FAIL wrap_rd_adr: got %0d, want 1", rd_adr);
    end
  endtask

  task automatic test_collision;
    logic [7:0] old_v, new_v;
    logic [7:0] exp_q [$];
    old_v = mem_model[5];
    new_v = old_v ^ 8'(1 + $urandom_range(0, 254));
    for (int i = 0; i < 7; i++) exp_q.push_back(mem_model[i]);
    spi_frame(7, 0, 1'b1, 5 * 8 - 1, 5, new_v);
    mem_model[5] = new_v;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL collide_byte%0d: got %h, want %h (old=%h new=%h)", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i], old_v, new_v);
      end
    end
    spi_frame(6, 0, 1'b1, -1, 0, 8'h00);
    checks++;
    if (rx_q.size() != 6 || rx_q[5] !== new_v) begin
      errors++;
      $display("FAIL collide_reread: got %p, want byte5=%h", rx_q, new_v);
    end
  endtask

  task automatic test_out_of_range;
    ram_write(40, 8'($urandom_range(0, 255)));
    ram_write(DEPTH, 8'($urandom_range(0, 255)));
    ram_write(255, 8'($urandom_range(0, 255)));
    ram_write(DEPTH - 1, 8'($urandom_range(0, 255)));
    spi_frame(FRAME_LEN, 0, 1'b1, -1, 0, 8'h00);
    for (int i = 0; i < FRAME_LEN; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== mem_model[i]) begin
        errors++;
        $display("FAIL oob_byte%0d: got %h, want %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, mem_model[i]);
      end
    end
  endtask

  task automatic test_random;
    int nb, d0;
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 6)); w++)
        ram_write(int'($urandom_range(0, 47)), 8'($urandom_range(0, 255)));
      nb = int'($urandom_range(1, 30));
      d0 = done_cnt;
      spi_frame(nb, 0, 1'b1, -1, 0, 8'h00);
      for (int i = 0; i < nb; i++) begin
        checks++;
        if (i >= rx_q.size() || rx_q[i] !== mem_model[i % FRAME_LEN]) begin
          errors++;
          $display("FAIL rand%0d_byte%0d: got %h, want %h", it, i,
                   (i < rx_q.size()) ? rx_q[i] : 8'hxx, mem_model[i % FRAME_LEN]);
        end
      end
      checks++;
      if (done_cnt - d0 != nb || rd_adr !== 8'(nb % FRAME_LEN)) begin
        errors++;
        $display("FAIL rand%0d_count: got done=%0d rd_adr=%0d, want done=%0d rd_adr=%0d",
                 it, done_cnt - d0, rd_adr, nb, nb % FRAME_LEN);
      end
    end
  endtask

  task automatic test_frame_err;
    int d0;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL err_before: got %b, want 0", frame_err);
    end
    d0 = done_cnt;
    spi_frame(0, 3, 1'b0, -1, 0, 8'h00);
    spi_cs_n = 1'b1;
    wait_clks(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL err_busy_2clk: got %b, want 1", busy);
    end
    wait_clks(1);
    checks++;
    if (busy !== 1'b0 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL err_3clk: got busy=%b err=%b, want busy=0 err=1", busy, frame_err);
    end
    checks++;
    if (done_cnt != d0 || rd_adr !== 8'd0) begin
      errors++;
      $display("FAIL err_no_advance: got done=%0d rd_adr=%0d, want done=0 rd_adr=0",
               done_cnt - d0, rd_adr);
    end
    wait_clks(HALF_SCK);
    spi_frame(1, 0, 1'b1, -1, 0, 8'h00);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== mem_model[0] || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL err_restart: got %p err=%b, want %h err=1", rx_q, frame_err, mem_model[0]);
    end
  endtask

  task automatic test_reset_mid;
    spi_frame(2, 3, 1'b0, -1, 0, 8'h00);
    checks++;
    if (busy !== 1'b1 || rd_adr !== 8'd2 || rx_q.size() != 2 ||
        rx_q[0] !== mem_model[0] || rx_q[1] !== mem_model[1]) begin
      errors++;
      $display("FAIL rstmid_pre: got busy=%b rd_adr=%0d rx=%p, want 1 2 %h %h",
               busy, rd_adr, rx_q, mem_model[0], mem_model[1]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({spi_miso, byte_done, rd_adr, busy, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_outputs: got miso=%b done=%b rd_adr=%0d busy=%b err=%b, want all 0",
               spi_miso, byte_done, rd_adr, busy, frame_err);
    end
    spi_cs_n = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(HALF_SCK);
    spi_frame(FRAME_LEN, 0, 1'b1, -1, 0, 8'h00);
    for (int i = 0; i < FRAME_LEN; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== mem_model[i]) begin
        errors++;
        $display("FAIL rstmid_ram%0d: got %h, want %h", i,
                 (i < rx_q.size()) ? rx_q[i] : 8'hxx, mem_model[i]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem_model[a] = 8'h00;
    wait_clks(2);
    test_reset();
    test_basic();
    test_wrap();
    test_collision();
    test_out_of_range();
    test_random();
    test_frame_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
